// File: rtl/beta_pipe_cu.sv
// beta_pipe_cu: pipelined Beta control unit with prioritised interrupts, load-use interlock and branch annulment
module beta_pipe_cu #(
  parameter int IRQ_LINES = 4,
  parameter bit LOAD_STALL = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          instruction,
  input  logic                 Z,
  input  logic                 SUPER,
  input  logic [IRQ_LINES-1:0] IRQ,
  output logic [2:0]           PCSEL,
  output logic                 RA2SEL,
  output logic                 STALL,
  output logic                 ANNUL,
  output logic [3:0]           IRQ_ID,
  output logic [5:0]           ALUFN,
  output logic                 ASEL,
  output logic                 BSEL,
  output logic                 MOE,
  output logic                 MWR,
  output logic                 WASEL,
  output logic [1:0]           WDSEL,
  output logic                 WERF
);
  typedef struct packed {
    logic [5:0] alufn;
    logic       asel;
    logic       bsel;
    logic       moe;
    logic       mwr;
    logic       wasel;
    logic [1:0] wdsel;
    logic       werf;
    logic       ld;
    logic [4:0] rc;
  } ctl_t;

  logic [5:0] op;
  logic [4:0] rc, ra, rb;
  ctl_t dec, nxt, alu_q;
  logic [5:0] mem_q;
  logic [3:0] wb_q;
  logic [2:0] dec_pcsel;
  logic dec_ra2sel, hazard, take, annul_q, hold;
  logic [IRQ_LINES-1:0] pend, clr;
  logic [3:0] irq_idx;
  logic unused_ok;

  assign op = instruction[31:26];
  assign rc = instruction[25:21];
  assign ra = instruction[20:16];
  assign rb = instruction[15:11];
  assign unused_ok = ^instruction[10:0];

  // opcode decode of the RF-stage instruction into a full control word
  always_comb begin
    dec = '0;
    dec.rc = rc;
    dec_pcsel = 3'b000;
    dec_ra2sel = 1'b0;
    if (op[5]) begin
      dec.alufn = op;
      dec.bsel = op[4];
      dec.wdsel = 2'b01;
      dec.werf = 1'b1;
    end else if (op == 6'b011000 || op == 6'b011111) begin
      dec.alufn = op[0] ? 6'b111111 : 6'b100000;
      dec.asel = op[0];
      dec.bsel = ~op[0];
      dec.moe = 1'b1;
      dec.wdsel = 2'b10;
      dec.werf = 1'b1;
      dec.ld = 1'b1;
    end else if (op == 6'b011001) begin
      dec.alufn = 6'b100000;
      dec.bsel = 1'b1;
      dec.mwr = 1'b1;
      dec_ra2sel = 1'b1;
    end else if (op == 6'b011011 || op == 6'b011100 || op == 6'b011101) begin
      dec.werf = 1'b1;
      dec_pcsel = (op == 6'b011011) ? 3'b010 : {2'b00, Z ^ op[0]};
    end else begin
      dec.wasel = 1'b1;
      dec.werf = 1'b1;
      dec_pcsel = 3'b011;
    end
  end

  // a load in the ALU slot whose destination feeds this instruction costs one bubble
  assign hazard = LOAD_STALL && alu_q.ld && alu_q.rc != 5'd31 &&
                  (alu_q.rc == ra || (op[5:4] == 2'b10 && alu_q.rc == rb) || (op == 6'b011001 && alu_q.rc == rc));
  assign hold  = RESET || annul_q;
  assign STALL = !hold && hazard;
  assign take  = !hold && !hazard && |pend && !SUPER;

  // lowest pending line wins
  always_comb begin
    irq_idx = 4'd0;
    for (int i = IRQ_LINES - 1; i >= 0; i--) if (pend[i]) irq_idx = 4'(i);
  end

  assign clr    = take ? (IRQ_LINES'(1) << irq_idx) : '0;
  assign IRQ_ID = take ? irq_idx : 4'd0;
  assign PCSEL  = hold ? 3'b000 : take ? 3'b100 : STALL ? 3'b000 : dec_pcsel;
  assign RA2SEL = (hold || take) ? 1'b0 : dec_ra2sel;
  assign ANNUL  = PCSEL != 3'b000;

  // control word entering the ALU slot: bubble, trap or the decoded instruction
  always_comb begin
    nxt = dec;
    if (hold || STALL) nxt = '0;
    else if (take) begin
      nxt = '0;
      nxt.wasel = 1'b1;
      nxt.werf = 1'b1;
    end
  end

  // stage slots, sticky interrupt pending bits and the annul flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend <= '0;
      annul_q <= 1'b0;
      alu_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
    end else begin
      pend <= (pend & ~clr) | IRQ;
      annul_q <= ANNUL;
      alu_q <= nxt;
      mem_q <= {alu_q.moe, alu_q.mwr, alu_q.wasel, alu_q.wdsel, alu_q.werf};
      wb_q <= mem_q[3:0];
    end
  end

  assign ALUFN = RESET ? 6'd0 : alu_q.alufn;
  assign ASEL  = !RESET && alu_q.asel;
  assign BSEL  = !RESET && alu_q.bsel;
  assign MOE   = !RESET && mem_q[5];
  assign MWR   = !RESET && mem_q[4];
  assign WASEL = !RESET && wb_q[3];
  assign WDSEL = RESET ? 2'd0 : wb_q[2:1];
  assign WERF  = !RESET && wb_q[0];
endmodule

// File: tb/tb_beta_pipe_cu.sv
// tb_beta_pipe_cu: directed and random checks of beta_pipe_cu against a cycle-level reference model
module tb_beta_pipe_cu;
  logic CLK = 1'b0;
  logic RESET, Z, SUPER;
  logic [31:0] instruction;
  logic [3:0] IRQ;
  logic [2:0] PCSEL;
  logic RA2SEL, STALL, ANNUL, ASEL, BSEL, MOE, MWR, WASEL, WERF;
  logic [3:0] IRQ_ID;
  logic [5:0] ALUFN;
  logic [1:0] WDSEL;
  logic [2:0] unused_pcsel2;
  logic unused_ra2sel2, stall2, unused_annul2, unused_asel2, unused_bsel2, unused_moe2, unused_mwr2, unused_wasel2, unused_werf2;
  logic [3:0] unused_irq_id2;
  logic [5:0] unused_alufn2;
  logic [1:0] unused_wdsel2;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit [5:0] alufn;
    bit asel, bsel, moe, mwr, wasel;
    bit [1:0] wdsel;
    bit werf, ld;
    bit [4:0] rc;
  } w_t;

  w_t hist[$];
  logic [3:0] pend;
  bit annul;
  logic [2:0] obs_pcsel;
  logic obs_stall, obs_annul, obs_stall2, obs_werf, obs_wasel, obs_moe, obs_bsel;
  logic [3:0] obs_irq_id;
  logic [5:0] obs_alufn;

  beta_pipe_cu #(.IRQ_LINES(4), .LOAD_STALL(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .instruction(instruction), .Z(Z), .SUPER(SUPER), .IRQ(IRQ),
    .PCSEL(PCSEL), .RA2SEL(RA2SEL), .STALL(STALL), .ANNUL(ANNUL), .IRQ_ID(IRQ_ID),
    .ALUFN(ALUFN), .ASEL(ASEL), .BSEL(BSEL), .MOE(MOE), .MWR(MWR),
    .WASEL(WASEL), .WDSEL(WDSEL), .WERF(WERF)
  );

  beta_pipe_cu #(.IRQ_LINES(4), .LOAD_STALL(1'b0)) dut_nostall (
    .CLK(CLK), .RESET(RESET), .instruction(instruction), .Z(Z), .SUPER(SUPER), .IRQ(IRQ),
    .PCSEL(unused_pcsel2), .RA2SEL(unused_ra2sel2), .STALL(stall2), .ANNUL(unused_annul2), .IRQ_ID(unused_irq_id2),
    .ALUFN(unused_alufn2), .ASEL(unused_asel2), .BSEL(unused_bsel2), .MOE(unused_moe2), .MWR(unused_mwr2),
    .WASEL(unused_wasel2), .WDSEL(unused_wdsel2), .WERF(unused_werf2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] c, input logic [4:0] a, input logic [4:0] b);
    return {op, c, a, b, 11'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic decode(input logic [31:0] ins, input bit z, output w_t w, output logic [2:0] pc, output bit ra2);
    logic [5:0] op;
    op = ins[31:26];
    w = '{default: 0};
    w.rc = ins[25:21];
    pc = 3'b000;
    ra2 = 1'b0;
    casez (op)
      6'b10????: begin w.alufn = op; w.wdsel = 2'b01; w.werf = 1; end
      6'b11????: begin w.alufn = op; w.bsel = 1; w.wdsel = 2'b01; w.werf = 1; end
      6'b011000: begin w.alufn = 6'b100000; w.bsel = 1; w.moe = 1; w.wdsel = 2'b10; w.werf = 1; w.ld = 1; end
      6'b011111: begin w.alufn = 6'b111111; w.asel = 1; w.moe = 1; w.wdsel = 2'b10; w.werf = 1; w.ld = 1; end
      6'b011001: begin w.alufn = 6'b100000; w.bsel = 1; w.mwr = 1; ra2 = 1; end
      6'b011011: begin w.werf = 1; pc = 3'b010; end
      6'b011100: begin w.werf = 1; pc = z ? 3'b001 : 3'b000; end
      6'b011101: begin w.werf = 1; pc = z ? 3'b000 : 3'b001; end
      default:   begin w.wasel = 1; w.werf = 1; pc = 3'b011; end
    endcase
  endtask

  task automatic cyc(input bit rst, input logic [31:0] ins, input bit z, input bit sup, input logic [3:0] irq);
    w_t d, iss, bub, a, m, wb;
    logic [2:0] pc, dpc;
    bit ra2, dra2, haz, take;
    logic [3:0] id;
    logic [5:0] op;
    bub = '{default: 0};
    RESET = rst; instruction = ins; Z = z; SUPER = sup; IRQ = irq;
    #1;
    decode(ins, z, d, dpc, dra2);
    op = ins[31:26];
    a = hist[0]; m = hist[1]; wb = hist[2];
    haz = a.ld && a.rc != 5'd31 && (a.rc == ins[20:16] || (op[5:4] == 2'b10 && a.rc == ins[15:11]) || (op == 6'b011001 && a.rc == ins[25:21]));
    take = 0; id = 0; pc = 0; ra2 = 0; iss = bub;
    if (rst || annul) haz = 0;
    else begin
      take = !haz && pend != 0 && !sup;
      if (take) begin
        for (int i = 3; i >= 0; i--) if (pend[i]) id = 4'(i);
        pc = 3'b100; iss.wasel = 1; iss.werf = 1;
      end else if (haz) ra2 = dra2;
      else begin pc = dpc; ra2 = dra2; iss = d; end
    end
    if (rst) begin a = bub; m = bub; wb = bub; end
    chk("pcsel", PCSEL, pc);
    chk("ra2sel", RA2SEL, ra2);
    chk("stall", STALL, haz);
    chk("annul", ANNUL, pc != 0);
    chk("irq_id", IRQ_ID, id);
    chk("alufn", ALUFN, a.alufn);
    chk("asel", ASEL, a.asel);
    chk("bsel", BSEL, a.bsel);
    chk("moe", MOE, m.moe);
    chk("mwr", MWR, m.mwr);
    chk("wasel", WASEL, wb.wasel);
    chk("wdsel", WDSEL, wb.wdsel);
    chk("werf", WERF, wb.werf);
    chk("stall_nointerlock", stall2, 1'b0);
    obs_pcsel = PCSEL; obs_stall = STALL; obs_annul = ANNUL; obs_stall2 = stall2; obs_werf = WERF;
    obs_wasel = WASEL; obs_moe = MOE; obs_bsel = BSEL; obs_irq_id = IRQ_ID; obs_alufn = ALUFN;
    @(posedge CLK);
    #1;
    if (rst) begin
      pend = 0; annul = 0; hist = '{bub, bub, bub};
    end else begin
      if (take) pend[id] = 1'b0;
      pend = pend | irq;
      annul = pc != 0;
      hist = '{iss, hist[0], hist[1]};
    end
  endtask

  initial begin
    logic [31:0] f, ld, add, ins;
    logic [5:0] ops [12];
    logic [4:0] regs [3];
    w_t bub;
    bub = '{default: 0};
    hist = '{bub, bub, bub};
    pend = 0; annul = 0;
    ops = '{6'b100000, 6'b100001, 6'b110000, 6'b110101, 6'b011000, 6'b011111,
            6'b011001, 6'b011011, 6'b011100, 6'b011101, 6'b000000, 6'b010101};
    regs = '{5'd1, 5'd2, 5'd31};
    f = mk(6'b100000, 5'd10, 5'd11, 5'd12);
    cyc(1, f, 0, 0, 4'b0000);
    chk("reset_pcsel", obs_pcsel, 3'b000);
    chk("reset_werf", obs_werf, 1'b0);
    cyc(1, f, 0, 0, 4'b0000);
    cyc(0, mk(6'b110000, 5'd1, 5'd2, 5'd0), 0, 0, 4'b0000);
    cyc(0, mk(6'b100001, 5'd3, 5'd4, 5'd5), 0, 0, 4'b0000);
    chk("addc_alufn", obs_alufn, 6'b110000);
    chk("addc_bsel", obs_bsel, 1'b1);
    cyc(0, f, 0, 0, 4'b0000);
    chk("sub_alufn", obs_alufn, 6'b100001);
    chk("sub_bsel", obs_bsel, 1'b0);
    cyc(0, f, 0, 0, 4'b0000);
    chk("addc_wb_werf", obs_werf, 1'b1);
    ld = mk(6'b011000, 5'd1, 5'd2, 5'd0);
    add = mk(6'b100000, 5'd2, 5'd3, 5'd1);
    cyc(0, ld, 0, 0, 4'b0000);
    cyc(0, add, 0, 0, 4'b0000);
    chk("ldu_stall", obs_stall, 1'b1);
    chk("ldu_pcsel", obs_pcsel, 3'b000);
    chk("ldu_nointerlock", obs_stall2, 1'b0);
    cyc(0, add, 0, 0, 4'b0000);
    chk("ldu_stall_once", obs_stall, 1'b0);
    chk("ldu_bubble_alufn", obs_alufn, 6'd0);
    for (int i = 0; i < 3; i++) cyc(0, f, 0, 0, 4'b0000);
    cyc(0, mk(6'b011100, 5'd5, 5'd0, 5'd0), 1, 0, 4'b0000);
    chk("beq_pcsel", obs_pcsel, 3'b001);
    chk("beq_annul", obs_annul, 1'b1);
    cyc(0, f, 0, 0, 4'b0000);
    chk("beq_shadow_pcsel", obs_pcsel, 3'b000);
    for (int i = 0; i < 3; i++) cyc(0, f, 0, 0, 4'b0000);
    chk("beq_shadow_werf", obs_werf, 1'b0);
    cyc(0, mk(6'b011101, 5'd5, 5'd0, 5'd0), 1, 0, 4'b0000);
    chk("bne_pcsel", obs_pcsel, 3'b000);
    chk("bne_annul", obs_annul, 1'b0);
    cyc(0, f, 0, 0, 4'b0110);
    chk("irq_not_yet", obs_pcsel, 3'b000);
    cyc(0, f, 0, 0, 4'b0000);
    chk("irq_take1_pcsel", obs_pcsel, 3'b100);
    chk("irq_take1_id", obs_irq_id, 4'd1);
    cyc(0, f, 0, 0, 4'b0000);
    chk("irq_shadow", obs_pcsel, 3'b000);
    cyc(0, f, 0, 0, 4'b0000);
    chk("irq_take2_id", obs_irq_id, 4'd2);
    cyc(0, f, 0, 0, 4'b0000);
    cyc(0, f, 0, 1, 4'b0001);
    cyc(0, f, 0, 1, 4'b0000);
    chk("irq_super_block", obs_pcsel, 3'b000);
    cyc(0, f, 0, 0, 4'b0000);
    chk("irq_super_release", obs_pcsel, 3'b100);
    chk("irq_super_id", obs_irq_id, 4'd0);
    cyc(0, f, 0, 0, 4'b0000);
    cyc(0, mk(6'b000000, 5'd0, 5'd0, 5'd0), 0, 0, 4'b0000);
    chk("illop_pcsel", obs_pcsel, 3'b011);
    cyc(0, f, 0, 0, 4'b1000);
    cyc(1, f, 0, 0, 4'b0000);
    chk("rst_pcsel", obs_pcsel, 3'b000);
    chk("rst_stall", obs_stall, 1'b0);
    chk("rst_annul", obs_annul, 1'b0);
    chk("rst_irq_id", obs_irq_id, 4'd0);
    chk("rst_moe", obs_moe, 1'b0);
    chk("rst_alufn", obs_alufn, 6'd0);
    cyc(0, f, 0, 0, 4'b0000);
    chk("post_rst_no_take", obs_pcsel, 3'b000);
    chk("post_rst_werf", obs_werf, 1'b0);
    chk("post_rst_wasel", obs_wasel, 1'b0);
    for (int n = 0; n < 400; n++) begin
      ins = mk(ops[$urandom_range(0, 11)], regs[$urandom_range(0, 2)], regs[$urandom_range(0, 2)], regs[$urandom_range(0, 2)]);
      cyc($urandom_range(0, 49) == 0, ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
          ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
